gray_codec_pipe: RTL and testbench

Pipelined, parametrised Gray-code codec for the async FIFO pointer path and debug/status logic. Each transaction either decodes Gray to binary or encodes binary to Gray, selected per transaction. The block uses a valid/ready handshake with full backpressure and one transaction per cycle throughput. The prefix-XOR decode is split across STAGES register stages so wide pointers meet timing.

---
 rtl/gray_codec_pkg.sv | 27 ++
 rtl/gray_codec_stage.sv | 64 ++++++
 rtl/gray_codec_pipe.sv | 98 +++++++++
 tb/tb_gray_codec_pipe.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_codec_pkg.sv
// Shared types and helpers for the pipelined Gray-code codec.
// GRAY_STEP_CHECK_EN enables the sticky step-violation checker in the top.
package gray_codec_pkg;

    typedef enum logic {
        GRAY_DEC = 1'b0,
        BIN_ENC  = 1'b1
    } codec_mode_t;

    function automatic int chunk_size(input int bitsize, input int stages);
        return (bitsize + stages - 1) / stages;
    endfunction

    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [63:0] gray2bin(input logic [63:0] g);
        logic [63:0] b;
        b = g;
        for (int s = 1; s < 64; s = s * 2) begin
            b = b ^ (b >> s);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One codec pipeline stage: resolves Gray bits [HI:LO] using the carry
// from bit HI+1; the first stage also performs the binary->Gray encode.
module gray_codec_stage
    import gray_codec_pkg::*;
#(
    parameter int BITSIZE = 8,
    parameter int HI      = 7,
    parameter int LO      = 0,
    parameter bit FIRST   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_i,
    input  logic               valid_i,
    input  codec_mode_t        mode_i,
    input  logic [BITSIZE-1:0] data_i,
    output logic               valid_o,
    output codec_mode_t        mode_o,
    output logic [BITSIZE-1:0] data_o
);

    logic               valid_q;
    codec_mode_t        mode_q;
    logic [BITSIZE-1:0] data_q;
    logic [BITSIZE-1:0] data_d;

    always_comb begin
        logic acc;
        acc    = 1'b0;
        data_d = data_i;
        if (mode_i == BIN_ENC) begin
            if (FIRST) data_d = data_i ^ (data_i >> 1);
        end else begin
            // Walk down from the resolved carry bit through this chunk.
            for (int i = BITSIZE - 1; i >= 0; i--) begin
                if (i == HI + 1) begin
                    acc = data_i[i];
                end else if (i <= HI && i >= LO) begin
                    acc       = acc ^ data_i[i];
                    data_d[i] = acc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            mode_q  <= GRAY_DEC;
            data_q  <= '0;
        end else if (ld_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                mode_q <= mode_i;
                data_q <= data_d;
            end
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign data_o  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined Gray encode/decode with valid/ready backpressure.
// Define GRAY_STEP_CHECK_EN to add the sticky step_err output.
module gray_codec_pipe
    import gray_codec_pkg::*;
#(
    parameter int BITSIZE = 8,
    parameter int STAGES  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_mode,
    input  logic [BITSIZE-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mode,
    output logic [BITSIZE-1:0] out_data
`ifdef GRAY_STEP_CHECK_EN
    ,
    output logic               step_err
`endif
);

    localparam int C = chunk_size(BITSIZE, STAGES);

    if (BITSIZE < 1 || STAGES < 1 || STAGES > BITSIZE) begin : g_bad_cfg
        $error("gray_codec_pipe: STAGES must be in 1..BITSIZE");
    end

    logic [STAGES:0]    sv;
    codec_mode_t        sm [STAGES+1];
    logic [BITSIZE-1:0] sd [STAGES+1];
    logic [STAGES-1:0]  ld;

    assign sv[0] = in_valid;
    assign sm[0] = codec_mode_t'(in_mode);
    assign sd[0] = in_data;

    // A stage may load if it, or any stage after it, has a free slot.
    always_comb begin
        logic go;
        go = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go    = go | ~sv[k+1];
            ld[k] = go;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int HI = BITSIZE - 1 - k * C;
        localparam int LR = BITSIZE - (k + 1) * C;
        localparam int LO = (LR > 0) ? LR : 0;

        gray_codec_stage #(
            .BITSIZE(BITSIZE),
            .HI     (HI),
            .LO     (LO),
            .FIRST  (k == 0)
        ) u_stage (
            .clk    (clk),
            .rst    (rst),
            .ld_i   (ld[k]),
            .valid_i(sv[k]),
            .mode_i (sm[k]),
            .data_i (sd[k]),
            .valid_o(sv[k+1]),
            .mode_o (sm[k+1]),
            .data_o (sd[k+1])
        );
    end

    assign in_ready  = ld[0];
    assign out_valid = sv[STAGES];
    assign out_mode  = sm[STAGES];
    assign out_data  = sd[STAGES];

`ifdef GRAY_STEP_CHECK_EN
    logic [BITSIZE-1:0] prev_q;
    logic               have_q;
    logic               err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            have_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (in_valid && in_ready && !in_mode) begin
            prev_q <= in_data;
            have_q <= 1'b1;
            if (have_q && $countones(in_data ^ prev_q) > 1) err_q <= 1'b1;
        end
    end

    assign step_err = err_q;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe at STAGES = 2, 1 and 8.
// Each configuration has its own driver, reference queue and monitor.
module tb_gray_codec_pipe;

    logic clk;
    int   n_cmp = 0;
    int   n_bad = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_g2b(input logic [7:0] g);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    function automatic logic [7:0] ref_b2g(input logic [7:0] b);
        return b ^ (b >> 1);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int STG = (g == 0) ? 2 : ((g == 1) ? 1 : 8);

        logic       rst, in_valid, in_ready, in_mode;
        logic       out_valid, out_ready, out_mode;
        logic [7:0] in_data, out_data;
`ifdef GRAY_STEP_CHECK_EN
        logic       step_err;
`endif
        logic [8:0] q[$];
        logic [7:0] sprev;
        bit         shave, serr, done;
        bit         hold_v;
        logic [7:0] hold_d;
        logic       hold_m;

        gray_codec_pipe #(.BITSIZE(8), .STAGES(STG)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_mode  (in_mode),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_mode (out_mode),
            .out_data (out_data)
`ifdef GRAY_STEP_CHECK_EN
            ,
            .step_err (step_err)
`endif
        );

        task automatic cyc(input logic v, input logic md, input logic [7:0] dt,
                           input logic ordy, output bit acc);
            @(negedge clk);
`ifdef GRAY_STEP_CHECK_EN
            if (!rst) chk("step_err_track", 32'(step_err), 32'(serr));
`endif
            in_valid  = v;
            in_mode   = md;
            in_data   = dt;
            out_ready = ordy;
            #1;
            acc = v && in_ready;
            if (acc) begin
                q.push_back({md, md ? ref_b2g(dt) : ref_g2b(dt)});
                if (!md) begin
                    if (shave && $countones(dt ^ sprev) > 1) serr = 1'b1;
                    sprev = dt;
                    shave = 1'b1;
                end
            end
        endtask

        task automatic send(input logic md, input logic [7:0] dt, input logic ordy);
            bit acc;
            int n;
            n = 0;
            acc = 1'b0;
            while (!acc && n < 50) begin
                cyc(1'b1, md, dt, ordy, acc);
                n++;
            end
            chk("accept", 32'(acc), 32'd1);
        endtask

        task automatic drain();
            bit a;
            int n;
            n = 0;
            while (q.size() != 0 && n < 200) begin
                cyc(1'b0, 1'b0, 8'h00, 1'b1, a);
                n++;
            end
            chk("drain", 32'(q.size()), 32'd0);
        endtask

        task automatic do_reset();
            @(negedge clk);
            rst       = 1'b1;
            in_valid  = 1'b0;
            out_ready = 1'b0;
            q.delete();
            serr  = 1'b0;
            shave = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            #1;
        endtask

        always @(negedge clk) begin
            #2;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_data", 32'(out_data), 32'(hold_d));
                    chk("hold_mode", 32'(out_mode), 32'(hold_m));
                end
                hold_v = 1'b0;
                if (out_valid && out_ready) begin
                    chk("expected_out", 32'(q.size() != 0), 32'd1);
                    if (q.size() != 0) begin
                        logic [8:0] e;
                        e = q.pop_front();
                        chk("out_data", 32'(out_data), 32'(e[7:0]));
                        chk("out_mode", 32'(out_mode), 32'(e[8]));
                    end
                end else if (out_valid) begin
                    hold_v = 1'b1;
                    hold_d = out_data;
                    hold_m = out_mode;
                end
            end
        end

        initial begin
            bit acc;
            int n, cnt;
            done = 1'b0; rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
            in_data = 8'h00; out_ready = 1'b0; hold_v = 1'b0;
            do_reset();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
            chk("rst_out_mode", 32'(out_mode), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef GRAY_STEP_CHECK_EN
            chk("rst_step_err", 32'(step_err), 32'd0);
`endif
            // Latency of a lone decode, then a lone encode
            cyc(1'b1, 1'b0, 8'hC8, 1'b1, acc);
            chk("lat_accept", 32'(acc), 32'd1);
            n = 0;
            do begin
                cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
                n++;
            end while (!out_valid && n < 20);
            chk("latency", 32'(n), 32'(STG));
            chk("dec_C8", 32'(out_data), 32'h8F);
            send(1'b1, 8'h8F, 1'b1);
            drain();

            // Step checker sequence
            do_reset();
            send(1'b0, 8'h00, 1'b1);
            send(1'b0, 8'h01, 1'b1);
            send(1'b0, 8'h01, 1'b1);
            send(1'b1, 8'hFF, 1'b1);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
`ifdef GRAY_STEP_CHECK_EN
            chk("step_ok", 32'(step_err), 32'd0);
`endif
            send(1'b0, 8'h02, 1'b1);
            cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
`ifdef GRAY_STEP_CHECK_EN
            chk("step_set", 32'(step_err), 32'd1);
`endif
            send(1'b0, 8'h03, 1'b1);
            drain();
`ifdef GRAY_STEP_CHECK_EN
            chk("step_sticky", 32'(step_err), 32'd1);
`endif
            do_reset();
`ifdef GRAY_STEP_CHECK_EN
            chk("step_cleared", 32'(step_err), 32'd0);
`endif
            // Full-rate stream of every code
            cnt = 0;
            for (int x = 0; x < 256; x++) begin
                cyc(1'b1, 1'b0, 8'(x), 1'b1, acc);
                if (!acc) cnt++;
            end
            chk("stream_stalls", 32'(cnt), 32'd0);
            drain();

            // Backpressure: fill to capacity with alternating modes
            cnt = 0;
            for (int i = 0; i < STG + 3; i++) begin
                cyc(1'b1, 1'(i & 1), 8'($urandom), 1'b0, acc);
                if (acc) cnt++;
            end
            chk("capacity", 32'(cnt), 32'(STG));
            chk("full_in_ready", 32'(in_ready), 32'd0);
            drain();

            // Reset with items in flight discards them
            for (int i = 0; i < ((STG < 2) ? 1 : 2); i++) begin
                send(1'b0, 8'($urandom), 1'b0);
            end
            do_reset();
            chk("flush_out_valid", 32'(out_valid), 32'd0);
            send(1'b0, 8'h5A, 1'b1);
            drain();

            // Random traffic with random backpressure
            for (int i = 0; i < 500; i++) begin
                cyc(1'($urandom), 1'($urandom), 8'($urandom),
                    1'($urandom_range(0, 3) != 0), acc);
            end
            drain();
            done = 1'b1;
        end
    end

    initial begin
        wait (g_cfg[0].done && g_cfg[1].done && g_cfg[2].done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule
